seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode seven-segment display.
//  - Holds a packed hex value and scans one digit per time slot.
//  - Provides tear-free updates by committing new values only at frame boundaries.
//  - Adds leading-zero blanking, per-digit decimal points and 16-level PWM brightness.
//  - Sits between the numberle game/keypad logic and the board display pins.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_font_rom.sv | 16 +
 rtl/seg7_scan_driver.sv | 190 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   SEG_OFF_AL : active-low GFEDCBA pattern with every segment dark
//   hex_to_seg : nibble -> active-low GFEDCBA pattern (standard 0-F hex font)
package seg7_pkg;

    localparam logic [6:0] SEG_OFF_AL = 7'h7F;

    // Active-low font, bit 6 = G ... bit 0 = A.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = SEG_OFF_AL;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_font_rom.sv
// Combinational hex font lookup.
//   nibble  : 4-bit hex digit
//   pattern : active-low GFEDCBA segment pattern
module seg7_font_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Pure table lookup through the shared font function.
    always_comb begin
        pattern = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// New values are staged in pending registers and committed only when the
// scan wraps back to digit 0, so one frame never mixes old and new digits.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : 0 darkens the display and freezes the scan
//   load         : strobe capturing value / dp_in / blank_lz into pending regs
//   value        : hex nibbles, nibble 0 = rightmost digit
//   dp_in        : decimal point per digit
//   blank_lz     : leading-zero blanking enable
//   duty         : PWM brightness 0..15 (15 = full slot)
//   seg, dp, an  : registered display pins (polarity set by parameters)
//   frame_start  : 1-cycle pulse registered with the wrap to digit 0
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SLOT_LOG2      = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [3:0]              duty,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_LOG2-1:0] TICK_LAST = {SLOT_LOG2{1'b1}};
    localparam logic [6:0]           SEG_IDLE  = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_AL : ~SEG_OFF_AL;
    localparam logic                 DP_IDLE   = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{(AN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0}};

    logic [SLOT_LOG2-1:0]    tick_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] val_act_r, val_pend_r;
    logic [NUM_DIGITS-1:0]   dp_act_r, dp_pend_r;
    logic                    lz_act_r, lz_pend_r, pend_v_r;

    logic                    wrap_s;
    logic [3:0]              nib_s;
    logic                    dp_sel_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic                    blank_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [6:0]              font_al_s;
    logic [6:0]              seg_pin_s;
    logic                    dp_pin_s;
    logic [NUM_DIGITS-1:0]   an_pin_s;
    logic                    pwm_on_s;
    logic                    zero_run_s;

    // Last slot of the last digit while running: the frame boundary.
    always_comb begin
        wrap_s = enable && (tick_r == TICK_LAST) && (idx_r == IDX_LAST);
    end

    // Slot counter and digit index; both freeze while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r <= {SLOT_LOG2{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
        end else if (enable) begin
            tick_r <= tick_r + {{(SLOT_LOG2-1){1'b0}}, 1'b1};
            if (tick_r == TICK_LAST) begin
                if (idx_r == IDX_LAST) begin
                    idx_r <= {IDX_W{1'b0}};
                end else begin
                    idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            tick_r <= tick_r;
            idx_r  <= idx_r;
        end
    end

    // Pending capture and frame-boundary commit; a load on the wrap edge bypasses pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_act_r  <= {(4*NUM_DIGITS){1'b0}};
            dp_act_r   <= {NUM_DIGITS{1'b0}};
            lz_act_r   <= 1'b0;
            val_pend_r <= {(4*NUM_DIGITS){1'b0}};
            dp_pend_r  <= {NUM_DIGITS{1'b0}};
            lz_pend_r  <= 1'b0;
            pend_v_r   <= 1'b0;
        end else begin
            if (load) begin
                val_pend_r <= value;
                dp_pend_r  <= dp_in;
                lz_pend_r  <= blank_lz;
            end
            if (wrap_s && load) begin
                val_act_r <= value;
                dp_act_r  <= dp_in;
                lz_act_r  <= blank_lz;
                pend_v_r  <= 1'b0;
            end else if (wrap_s && pend_v_r) begin
                val_act_r <= val_pend_r;
                dp_act_r  <= dp_pend_r;
                lz_act_r  <= lz_pend_r;
                pend_v_r  <= 1'b0;
            end else if (load) begin
                pend_v_r  <= 1'b1;
            end else begin
                pend_v_r  <= pend_v_r;
            end
        end
    end

    // Leading-zero mask: walk from the leftmost digit down while nibbles stay zero.
    always_comb begin
        lz_mask_s  = {NUM_DIGITS{1'b0}};
        zero_run_s = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run_s   = zero_run_s && (val_act_r[4*k +: 4] == 4'h0);
            lz_mask_s[k] = lz_act_r && zero_run_s && (k != 0);
        end
    end

    // Select the current digit's nibble, dp, blank flag and anode bit.
    always_comb begin
        nib_s    = 4'h0;
        dp_sel_s = 1'b0;
        blank_s  = 1'b0;
        onehot_s = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_r == IDX_W'(k)) begin
                nib_s       = val_act_r[4*k +: 4];
                dp_sel_s    = dp_act_r[k];
                blank_s     = lz_mask_s[k];
                onehot_s[k] = 1'b1;
            end else begin
                onehot_s[k] = 1'b0;
            end
        end
    end

    seg7_font_rom u_font (
        .nibble  (nib_s),
        .pattern (font_al_s)
    );

    // PWM compare on the top tick nibble, then apply pin polarities.
    always_comb begin
        pwm_on_s = (tick_r[SLOT_LOG2-1 -: 4] <= duty);
        if (SEG_ACTIVE_LOW != 0) begin
            seg_pin_s = blank_s ? SEG_OFF_AL : font_al_s;
            dp_pin_s  = ~dp_sel_s;
        end else begin
            seg_pin_s = blank_s ? ~SEG_OFF_AL : ~font_al_s;
            dp_pin_s  = dp_sel_s;
        end
        if (AN_ACTIVE_LOW != 0) begin
            an_pin_s = pwm_on_s ? ~onehot_s : AN_IDLE;
        end else begin
            an_pin_s = pwm_on_s ? onehot_s : AN_IDLE;
        end
    end

    // Registered pins: dark on reset or while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg         <= SEG_IDLE;
            dp          <= DP_IDLE;
            an          <= AN_IDLE;
            frame_start <= 1'b0;
        end else if (!enable) begin
            seg         <= SEG_IDLE;
            dp          <= DP_IDLE;
            an          <= AN_IDLE;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_pin_s;
            dp          <= dp_pin_s;
            an          <= an_pin_s;
            frame_start <= wrap_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver (4 digits, 16-cycle slots).
// The reference model tracks the scan as a count of enabled cycles modulo one
// frame, plus displayed and pending values, and predicts every pin each cycle.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst, enable, load, blank_lz;
    logic [15:0] value;
    logic [3:0]  dp_in, duty;
    logic [6:0]  seg;
    logic        dp, frame_start;
    logic [3:0]  an;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SLOT_LOG2(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .duty(duty), .seg(seg), .dp(dp),
        .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Reference font, active-low GFEDCBA.
    logic [6:0] font_tab [16];

    // Model state: position in frame (0..63) and shown/pending contents.
    int          pos;
    logic [15:0] shown_v, pend_v_val;
    logic [3:0]  shown_dp, pend_dp;
    logic        shown_lz, pend_lz, pend_ok;

    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fs;
    logic [3:0]  exp_an;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Predict pins after the coming edge, then advance the model through it.
    task automatic model_edge();
        int digit, tk;
        logic blank;
        logic wrap;
        digit = pos / 16;
        tk    = pos % 16;
        if (rst || !enable) begin
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fs = 1'b0;
        end else begin
            blank = shown_lz && (digit != 0) && ((shown_v >> (4 * digit)) == 16'h0);
            exp_seg = blank ? 7'h7F : font_tab[(shown_v >> (4 * digit)) & 16'hF];
            exp_dp  = ~shown_dp[digit];
            exp_an  = (tk <= int'(duty)) ? (4'hF & ~(4'h1 << digit)) : 4'hF;
            exp_fs  = (pos == 63);
        end
        if (rst) begin
            pos = 0; shown_v = 16'h0; shown_dp = 4'h0; shown_lz = 1'b0;
            pend_v_val = 16'h0; pend_dp = 4'h0; pend_lz = 1'b0; pend_ok = 1'b0;
        end else begin
            wrap = enable && (pos == 63);
            if (enable) pos = (pos + 1) % 64;
            if (wrap && load) begin
                shown_v = value; shown_dp = dp_in; shown_lz = blank_lz; pend_ok = 1'b0;
            end else if (wrap && pend_ok) begin
                shown_v = pend_v_val; shown_dp = pend_dp; shown_lz = pend_lz; pend_ok = 1'b0;
            end else if (load) begin
                pend_ok = 1'b1;
            end
            if (load) begin
                pend_v_val = value; pend_dp = dp_in; pend_lz = blank_lz;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("dp", 32'(dp), 32'(exp_dp));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
    endtask

    // Random value biased toward leading zeros so blanking is exercised.
    function automatic logic [15:0] rand_value();
        logic [15:0] masks [4];
        masks[0] = 16'h000F; masks[1] = 16'h00FF; masks[2] = 16'h0FFF; masks[3] = 16'hFFFF;
        return 16'($urandom) & masks[$urandom_range(3, 0)];
    endfunction

    initial begin
        font_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        pos = 0; shown_v = 16'h0; shown_dp = 4'h0; shown_lz = 1'b0;
        pend_v_val = 16'h0; pend_dp = 4'h0; pend_lz = 1'b0; pend_ok = 1'b0;

        rst = 1'b1; enable = 1'b1; load = 1'b0; value = 16'h0;
        dp_in = 4'h0; blank_lz = 1'b0; duty = 4'd15;
        cycle();
        cycle();
        rst = 1'b0;

        // Plain scan of zeros at full brightness, then a mid-frame load.
        for (int i = 0; i < 100; i++) cycle();
        load = 1'b1; value = 16'h12AF; cycle(); load = 1'b0;
        for (int i = 0; i < 140; i++) cycle();

        // Leading-zero blanking with the dp on the blanked leftmost digit.
        load = 1'b1; value = 16'h0050; dp_in = 4'b1000; blank_lz = 1'b1; cycle();
        load = 1'b0;
        duty = 4'd3;
        for (int i = 0; i < 140; i++) cycle();

        // Disabled gap with two loads; only the second should be shown.
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            load = (i == 5 || i == 12);
            value = (i == 5) ? 16'h3333 : 16'hBEEF;
            blank_lz = 1'b0;
            cycle();
        end
        load = 1'b0; enable = 1'b1; duty = 4'd15;
        for (int i = 0; i < 140; i++) cycle();

        // Reset mid-frame while a load is pending.
        load = 1'b1; value = 16'h9876; cycle(); load = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 80; i++) cycle();

        // Randomized traffic, including loads that land on the wrap edge.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(599, 0) == 0);
            enable   = ($urandom_range(9, 0) != 0);
            load     = ($urandom_range(39, 0) == 0) || (pos == 63 && $urandom_range(1, 0) == 1);
            value    = rand_value();
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            if ($urandom_range(63, 0) == 0) duty = 4'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
